// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART with a receive FIFO.
// Build option: define UART_PARITY_EN to add an even-parity bit.
module uart_xcvr_param #(
    parameter int CLK_DIV       = 347,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             tx_start,
    input  logic [DATA_BITS-1:0]             tx_data,
    output logic                             tx_busy,
    output logic                             tx_done,
    output logic                             ser_tx,
    input  logic                             ser_rx,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic                             rx_frame_err,
    output logic                             rx_parity_err,
    output logic                             rx_overrun,
    input  logic                             clear_err,
    output logic [$clog2(RX_FIFO_DEPTH):0]   rx_count
);

    localparam int STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int CW       = $clog2(STOP_LEN) + 1;
    localparam int BW       = $clog2(DATA_BITS);
    localparam int AW       = $clog2(RX_FIFO_DEPTH);
    localparam int NW       = AW + 1;

    localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [CW-1:0] DONE_AT  = CW'(STOP_LEN - 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(RX_FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    // ------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------
    state_t                 tx_state;
    logic [CW-1:0]          tx_cnt;
    logic [BW-1:0]          tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_load;
`ifdef UART_PARITY_EN
    logic                   tx_par;
`endif

    // A new frame is taken from idle, or straight from the final stop cycle
    // so that a held tx_start produces back-to-back frames.
    assign tx_load = tx_start &&
                     ((tx_state == S_IDLE) ||
                      (tx_state == S_STOP && tx_cnt == STOP_END));

    // TX frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
            ser_tx   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_load) begin
                tx_state <= S_START;
                tx_cnt   <= '0;
                tx_shift <= tx_data;
`ifdef UART_PARITY_EN
                tx_par   <= ^tx_data;
`endif
                ser_tx   <= 1'b0;
                tx_busy  <= 1'b1;
            end else begin
                case (tx_state)
                    S_IDLE: begin
                        ser_tx  <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    S_START: begin
                        if (tx_cnt == BIT_END) begin
                            tx_cnt   <= '0;
                            tx_bit   <= '0;
                            tx_state <= S_DATA;
                            ser_tx   <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (tx_cnt == BIT_END) begin
                            tx_cnt <= '0;
                            if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                                tx_state <= S_PARITY;
                                ser_tx   <= tx_par;
`else
                                tx_state <= S_STOP;
                                ser_tx   <= 1'b1;
`endif
                            end else begin
                                tx_bit   <= tx_bit + BW'(1);
                                ser_tx   <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                            end
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        if (tx_cnt == BIT_END) begin
                            tx_cnt   <= '0;
                            tx_state <= S_STOP;
                            ser_tx   <= 1'b1;
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (tx_cnt == STOP_END) begin
                            tx_cnt   <= '0;
                            tx_state <= S_IDLE;
                            tx_busy  <= 1'b0;
                        end else begin
                            tx_cnt <= tx_cnt + CW'(1);
                            if (tx_cnt == DONE_AT) begin
                                tx_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        tx_state <= S_IDLE;
                        ser_tx   <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    state_t                 rx_state;
    logic [CW-1:0]          rx_cnt;
    logic [BW-1:0]          rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_push;
`ifdef UART_PARITY_EN
    logic                   rx_par;
`endif

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX frame sequencer: validates start at half-bit, then samples mid-bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par        <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        // Line back high means a glitch, not a frame
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + BW'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt       <= '0;
                        rx_state     <= S_IDLE;
                        rx_frame_err <= !rx_sync;
`ifdef UART_PARITY_EN
                        rx_parity_err <= (rx_par != ^rx_shift);
                        rx_push <= rx_sync && (rx_par == ^rx_shift);
`else
                        rx_push <= rx_sync;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    // ------------------------------------------------------------
    // Receive FIFO (first-word fall-through)
    // ------------------------------------------------------------
    logic [DATA_BITS-1:0]   mem [RX_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   full;
    logic                   pop;
    logic                   wr_en;

    assign rx_valid = (rx_count != '0);
    assign full     = (rx_count == FULL_CNT);
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en    = rx_push && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    // FIFO storage; contents are only meaningful behind the pointers
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   rx_count <= rx_count + NW'(1);
                2'b01:   rx_count <= rx_count - NW'(1);
                default: rx_count <= rx_count;
            endcase
            if (rx_push && full && !pop) begin
                rx_overrun <= 1'b1;
            end else if (clear_err) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb_uart_xcvr_param: randomized self-checking bench for uart_xcvr_param.
// Reference model: frame bit arithmetic plus a queue for the RX FIFO.
module tb_uart_xcvr_param;

    localparam int CD    = 16;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;
    localparam int FLEN  = NBITS * CD;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tx_start = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_busy;
    logic          tx_done;
    logic          ser_tx;
    logic          ser_rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_overrun;
    logic          clear_err = 1'b0;
    logic [2:0]    rx_count;

    logic          loop_en = 1'b0;
    logic          drv_rx = 1'b1;

    assign ser_rx = loop_en ? ser_tx : drv_rx;

    uart_xcvr_param #(
        .CLK_DIV(CD), .DATA_BITS(DB),
        .STOP_BITS(SB), .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .ser_tx(ser_tx), .ser_rx(ser_rx),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun), .clear_err(clear_err),
        .rx_count(rx_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int model_q[$];
    int model_ovr = 0;
    int last_bits[NBITS];

    task automatic chk(string tag, int obs, int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Level of frame bit k for payload d (start, LSB-first data, parity, stop)
    function automatic int exp_bit(int d, int k);
        if (k == 0) return 0;
        if (k <= DB) return (d >> (k - 1)) & 1;
        if (PB == 1 && k == DB + 1) return $countones(d & 255) & 1;
        return 1;
    endfunction

    function automatic void mdl_push(int d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovr = 1;
    endfunction

    always @(negedge clock) begin
        if (rx_frame_err === 1'b1) fe_cnt++;
        if (rx_parity_err === 1'b1) pe_cnt++;
    end

    task automatic tx_frame(int d);
        int mism;
        int done_cyc;
        int pulses;
        int fall;
        mism = 0; done_cyc = -1; pulses = 0; fall = -1;
        @(negedge clock);
        tx_start = 1'b1;
        tx_data = DB'(d);
        @(posedge clock);
        @(negedge clock);
        tx_start = 1'b0;
        for (int c = 1; c <= FLEN + 1; c++) begin
            if (c <= FLEN) begin
                if (ser_tx !== exp_bit(d, (c - 1) / CD)) mism++;
                if (tx_busy !== 1'b1) mism++;
                if ((c - 1) % CD == CD / 2)
                    last_bits[(c - 1) / CD] = int'(ser_tx);
            end
            if (tx_done === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (tx_busy === 1'b0 && fall < 0) fall = c;
            if (c != FLEN + 1) @(negedge clock);
        end
        chk("tx_wave", mism, 0);
        chk("tx_done_cycle", done_cyc, FLEN);
        chk("tx_done_pulses", pulses, 1);
        chk("tx_busy_fall", fall, FLEN + 1);
        if (loop_en) mdl_push(d);
    endtask

    // Drive one frame on ser_rx; entered and left on a falling clock edge
    task automatic rx_drive(int d, int stop_val, int par_flip);
        int b;
        for (int k = 0; k < NBITS; k++) begin
            b = exp_bit(d, k);
            if (k == 1 + DB + PB) b = stop_val;
            if (PB == 1 && k == 1 + DB) b = b ^ par_flip;
            drv_rx = b[0];
            repeat (CD) @(negedge clock);
        end
        drv_rx = 1'b1;
        repeat (CD) @(negedge clock);
    endtask

    task automatic chk_state(string tag);
        chk({tag, "_count"}, int'(rx_count), model_q.size());
        chk({tag, "_overrun"}, int'(rx_overrun), model_ovr);
    endtask

    task automatic do_clear();
        @(negedge clock);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        model_ovr = 0;
        chk("overrun_clear", int'(rx_overrun), 0);
    endtask

    task automatic drain();
        int e;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            chk("pop_valid", int'(rx_valid), 1);
            chk("pop_data", int'(rx_data), e);
            rx_ready = 1'b1;
            @(negedge clock);
            rx_ready = 1'b0;
        end
        chk("drain_count", int'(rx_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        int a;
        int b;
        int n;
        int fe0;
        int pe0;
        int gap;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_ser_tx", int'(ser_tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_count", int'(rx_count), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_ferr", int'(rx_frame_err), 0);
        chk("rst_perr", int'(rx_parity_err), 0);
        chk("rst_ovr", int'(rx_overrun), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Fixed frames through loopback
        loop_en = 1'b1;
        tx_frame(8'h0F);
        drain();
        tx_frame(8'h3D);
        chk("loop_valid", int'(rx_valid), 1);
        chk_state("loop3d");
        drain();

        // Random loopback frames, draining at random
        for (int i = 0; i < 7; i++) begin
            d = $urandom_range(0, 255);
            tx_frame(d);
            chk_state("rnd");
            if ($urandom_range(0, 2) == 0) drain();
        end
        do_clear();
        drain();

        // Overrun: five frames into a four-deep FIFO
        loop_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            rx_drive(i, 1, 0);
            mdl_push(i);
        end
        chk_state("ovr5");
        do_clear();
        drain();

        // Random burst with random idle gaps on the RX pin
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, 255);
            rx_drive(d, 1, 0);
            mdl_push(d);
            gap = $urandom_range(0, 20);
            repeat (gap) @(negedge clock);
        end
        chk_state("burst");
        do_clear();
        drain();

        // Short glitch: false start, nothing pushed, no flags
        fe0 = fe_cnt;
        pe0 = pe_cnt;
        drv_rx = 1'b0;
        repeat (4) @(negedge clock);
        drv_rx = 1'b1;
        repeat (3 * CD) @(negedge clock);
        chk("glitch_count", int'(rx_count), 0);
        chk("glitch_ferr", fe_cnt - fe0, 0);
        chk("glitch_perr", pe_cnt - pe0, 0);

        // Stop bit forced low
        fe0 = fe_cnt;
        rx_drive($urandom_range(0, 255), 0, 0);
        chk("ferr_pulses", fe_cnt - fe0, 1);
        chk("ferr_count", int'(rx_count), 0);

        // Reset in the middle of a TX frame
        loop_en = 1'b1;
        @(negedge clock);
        tx_start = 1'b1;
        tx_data = DB'($urandom_range(0, 255));
        @(posedge clock);
        @(negedge clock);
        tx_start = 1'b0;
        repeat (5 * CD) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_ser_tx", int'(ser_tx), 1);
        chk("mid_rst_busy", int'(tx_busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        tx_frame($urandom_range(0, 255));
        drain();

        // Back-to-back frames with tx_start held high
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        @(negedge clock);
        tx_start = 1'b1;
        tx_data = DB'(a);
        @(posedge clock);
        @(negedge clock);
        tx_data = DB'(b);
        n = 0;
        for (int c = 1; c <= FLEN; c++) begin
            if (tx_busy !== 1'b1) n++;
            @(negedge clock);
        end
        tx_start = 1'b0;
        chk("b2b_busy_gaps", n, 0);
        chk("b2b_busy", int'(tx_busy), 1);
        chk("b2b_start_bit", int'(ser_tx), 0);
        repeat (FLEN + 2 * CD) @(negedge clock);
        mdl_push(a);
        mdl_push(b);
        chk_state("b2b");
        drain();

`ifdef UART_PARITY_EN
        // Parity bit on the line and a corrupted parity on RX
        tx_frame(8'h07);
        chk("tx_par_bit", last_bits[DB + 1], 1);
        drain();
        loop_en = 1'b0;
        pe0 = pe_cnt;
        rx_drive(8'h07, 1, 1);
        chk("perr_pulses", pe_cnt - pe0, 1);
        chk("perr_count", int'(rx_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
